// File: rtl/i2c_snapshot_ctrl.sv
// Coherent x/y/status snapshot for the I2C read-only slave.
// Freezes on bus activity, buffers one update and commits it on idle.
module i2c_snapshot_ctrl #(
   parameter int unsigned FREEZE_TIMEOUT = 65535,
   parameter logic [2:0]  TX_STATE_CODE  = 3'd3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       upd_valid,
   input  logic [7:0] upd_x,
   input  logic [7:0] upd_y,
   input  logic       upd_err,
   input  logic [2:0] i2c_state,
   output logic [7:0] x_pos,
   output logic [7:0] y_pos,
   output logic [7:0] status,
   output logic       frozen
);

   localparam int TW = (FREEZE_TIMEOUT > 1) ? $clog2(FREEZE_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMAX = TW'(FREEZE_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_LIVE, S_FROZEN, S_COMMIT, S_HOLD
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    x_q, x_d, y_q, y_d;
   logic          err_q, err_d;
   logic [3:0]    seq_q, seq_d;
   logic          nd_q, nd_d, ovf_q, ovf_d, to_q, to_d;
   logic          pv_q, pv_d;
   logic [7:0]    px_q, px_d, py_q, py_d;
   logic          pe_q, pe_d;
   logic [1:0]    txc_q, txc_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic          ovfn_q, ovfn_d, ton_q, ton_d;
   logic          ptx_q, ptx_d;
   logic          frz_q, frz_d;

   logic          bus_idle, tx_edge, full, apply;
   logic [7:0]    ax, ay;
   logic          ae;

   assign bus_idle = (i2c_state == 3'd0);
   assign tx_edge  = (i2c_state == TX_STATE_CODE) && !ptx_q;
   assign full     = (txc_q == 2'd3);

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      err_d   = err_q;
      seq_d   = seq_q;
      nd_d    = nd_q;
      ovf_d   = ovf_q;
      to_d    = to_q;
      pv_d    = pv_q;
      px_d    = px_q;
      py_d    = py_q;
      pe_d    = pe_q;
      txc_d   = txc_q;
      tmr_d   = tmr_q;
      ovfn_d  = ovfn_q;
      ton_d   = ton_q;
      ptx_d   = (i2c_state == TX_STATE_CODE);
      apply   = 1'b0;
      ax      = upd_x;
      ay      = upd_y;
      ae      = upd_err;
      unique case (state_q)
         S_LIVE: begin
            if (!bus_idle) begin
               state_d = S_FROZEN;
               txc_d   = 2'd0;
               tmr_d   = '0;
               ovfn_d  = 1'b0;
               ton_d   = 1'b0;
               if (upd_valid) begin
                  pv_d = 1'b1;
                  px_d = upd_x;
                  py_d = upd_y;
                  pe_d = upd_err;
               end
            end else if (upd_valid) begin
               apply = 1'b1;
            end
         end
         S_FROZEN: begin
            if (upd_valid) begin
               pv_d = 1'b1;
               px_d = upd_x;
               py_d = upd_y;
               pe_d = upd_err;
               if (pv_q) ovfn_d = 1'b1;
            end
            if (tx_edge && !full) txc_d = txc_q + 2'd1;
            tmr_d = tmr_q + 1'b1;
            if (tmr_q == TMAX) begin
               ton_d   = 1'b1;
               state_d = S_COMMIT;
            end else if (bus_idle) begin
               state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            // Flags are untouched while frozen, so they still hold their entry values.
            nd_d  = nd_q & ~full;
            ovf_d = (ovf_q & ~full) | ovfn_q | (upd_valid & pv_q);
            to_d  = (to_q & ~full) | ton_q;
            if (upd_valid) begin
               apply = 1'b1;
            end else if (pv_q) begin
               apply = 1'b1;
               ax    = px_q;
               ay    = py_q;
               ae    = pe_q;
            end
            pv_d    = 1'b0;
            ovfn_d  = 1'b0;
            ton_d   = 1'b0;
            state_d = (ton_q && !bus_idle) ? S_HOLD : S_LIVE;
         end
         S_HOLD: begin
            if (upd_valid) apply = 1'b1;
            if (bus_idle) state_d = S_LIVE;
         end
         default: state_d = S_LIVE;
      endcase
      if (apply) begin
         x_d   = ax;
         y_d   = ay;
         err_d = ae;
         seq_d = seq_q + 4'd1;
         nd_d  = 1'b1;
      end
      frz_d = (state_d == S_FROZEN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_LIVE;
         x_q     <= '0;
         y_q     <= '0;
         err_q   <= 1'b0;
         seq_q   <= '0;
         nd_q    <= 1'b0;
         ovf_q   <= 1'b0;
         to_q    <= 1'b0;
         pv_q    <= 1'b0;
         px_q    <= '0;
         py_q    <= '0;
         pe_q    <= 1'b0;
         txc_q   <= '0;
         tmr_q   <= '0;
         ovfn_q  <= 1'b0;
         ton_q   <= 1'b0;
         ptx_q   <= 1'b0;
         frz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         err_q   <= err_d;
         seq_q   <= seq_d;
         nd_q    <= nd_d;
         ovf_q   <= ovf_d;
         to_q    <= to_d;
         pv_q    <= pv_d;
         px_q    <= px_d;
         py_q    <= py_d;
         pe_q    <= pe_d;
         txc_q   <= txc_d;
         tmr_q   <= tmr_d;
         ovfn_q  <= ovfn_d;
         ton_q   <= ton_d;
         ptx_q   <= ptx_d;
         frz_q   <= frz_d;
      end
   end

   assign x_pos  = x_q;
   assign y_pos  = y_q;
   assign status = {nd_q, ovf_q, to_q, err_q, seq_q};
   assign frozen = frz_q;

endmodule

// File: tb/tb_i2c_snapshot_ctrl.sv
// Bench for i2c_snapshot_ctrl: directed plan items plus randomized
// transactions checked against a transaction-level model.
module tb_i2c_snapshot_ctrl;

   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       upd_valid;
   logic [7:0] upd_x, upd_y;
   logic       upd_err;
   logic [2:0] i2c_state;
   logic [7:0] x_pos, y_pos, status;
   logic       frozen;

   int checks = 0;
   int errors = 0;

   // model of the published snapshot
   logic [7:0] m_x, m_y;
   logic       m_err, m_nd, m_ovf, m_to;
   int         m_seq;

   // transaction description
   int         q_s[$];
   bit         q_u[$];
   logic [7:0] q_ux[$], q_uy[$];
   bit         q_ue[$];

   i2c_snapshot_ctrl #(.FREEZE_TIMEOUT(TO), .TX_STATE_CODE(3'd3)) dut (
      .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid),
      .upd_x(upd_x), .upd_y(upd_y), .upd_err(upd_err),
      .i2c_state(i2c_state), .x_pos(x_pos), .y_pos(y_pos),
      .status(status), .frozen(frozen)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] m_status();
      logic [3:0] s;
      s = 4'(m_seq);
      return {m_nd, m_ovf, m_to, m_err, s};
   endfunction

   task automatic m_zero();
      m_x = 0; m_y = 0; m_err = 0; m_nd = 0;
      m_ovf = 0; m_to = 0; m_seq = 0;
   endtask

   task automatic m_apply(input logic [7:0] x, input logic [7:0] y,
                          input logic e);
      m_x = x; m_y = y; m_err = e;
      m_seq = (m_seq + 1) % 16;
      m_nd = 1'b1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic fz);
      chk({tag, ".x"}, x_pos, m_x);
      chk({tag, ".y"}, y_pos, m_y);
      chk({tag, ".status"}, status, m_status());
      chk({tag, ".frozen"}, {7'd0, frozen}, {7'd0, fz});
   endtask

   task automatic live_upd(input logic [7:0] x, input logic [7:0] y,
                           input logic e, input logic [2:0] st);
      i2c_state = st;
      upd_valid = 1'b1; upd_x = x; upd_y = y; upd_err = e;
      tick();
      upd_valid = 1'b0;
      m_apply(x, y, e);
      chk_all("live", 1'b0);
   endtask

   task automatic do_reset();
      i2c_state = 0; upd_valid = 0; rst_n = 1'b0;
      tick();
      m_zero();
      chk_all("rst", 1'b0);
      rst_n = 1'b1;
      tick();
      chk_all("rst_rel", 1'b0);
   endtask

   task automatic clr_txn();
      q_s.delete(); q_u.delete();
      q_ux.delete(); q_uy.delete(); q_ue.delete();
   endtask

   task automatic push(input int s, input bit u, input logic [7:0] x,
                       input logic [7:0] y, input bit e);
      q_s.push_back(s); q_u.push_back(u);
      q_ux.push_back(x); q_uy.push_back(y); q_ue.push_back(e);
   endtask

   task automatic gen_txn();
      int len, s;
      clr_txn();
      len = $urandom_range(3, 9);
      for (int i = 0; i < len; i++) begin
         if (i == 0) s = 1;
         else if (i % 2 == 1 && $urandom_range(0, 3) != 0) s = 3;
         else s = $urandom_range(4, 5);
         push(s, $urandom_range(0, 2) == 0, 8'($urandom), 8'($urandom),
              1'($urandom));
      end
   endtask

   // Runs q_s as one bus transaction, then predicts the committed snapshot.
   task automatic run_txn(input bit cu, input logic [7:0] cx,
                          input logic [7:0] cy, input bit ce);
      int ntx, nup, prev;
      logic [7:0] lx, ly;
      bit le;
      ntx = 0; nup = 0; prev = 0;
      lx = 0; ly = 0; le = 0;
      foreach (q_s[i]) begin
         i2c_state = 3'(q_s[i]);
         upd_valid = q_u[i];
         upd_x = q_ux[i]; upd_y = q_uy[i]; upd_err = q_ue[i];
         if (q_u[i]) begin
            nup++; lx = q_ux[i]; ly = q_uy[i]; le = q_ue[i];
         end
         if (i > 0 && q_s[i] == 3 && prev != 3) ntx++;
         prev = q_s[i];
         tick();
         upd_valid = 1'b0;
         chk_all("hold", 1'b1);
      end
      i2c_state = 0;
      tick();
      chk_all("commit", 1'b0);
      upd_valid = cu; upd_x = cx; upd_y = cy; upd_err = ce;
      tick();
      upd_valid = 1'b0;
      if (ntx >= 3) begin
         m_nd = 0; m_ovf = 0; m_to = 0;
      end
      if (nup >= 2) m_ovf = 1;
      if (cu) begin
         if (nup >= 1) m_ovf = 1;
         m_apply(cx, cy, ce);
      end else if (nup >= 1) begin
         m_apply(lx, ly, le);
      end
      chk_all("after", 1'b0);
   endtask

   initial begin
      int n;
      upd_valid = 0; upd_x = 0; upd_y = 0; upd_err = 0;
      i2c_state = 0; rst_n = 1'b1;
      #2;
      do_reset();

      // idle bus live update
      live_upd(8'h12, 8'h34, 1'b0, 3'd0);
      chk("plan1.status", status, 8'h81);

      // full read with one update in flight
      clr_txn();
      push(1, 0, 0, 0, 0); push(2, 0, 0, 0, 0); push(3, 0, 0, 0, 0);
      push(4, 1, 8'h55, 8'h66, 0); push(5, 0, 0, 0, 0);
      push(3, 0, 0, 0, 0); push(4, 0, 0, 0, 0); push(5, 0, 0, 0, 0);
      push(3, 0, 0, 0, 0);
      run_txn(0, 0, 0, 0);
      chk("plan2.x", x_pos, 8'h55);
      chk("plan2.status", status, 8'h82);

      // two updates in a freeze -> overflow; next full read clears it
      clr_txn();
      push(1, 1, 8'h01, 8'h02, 0); push(3, 0, 0, 0, 0);
      push(4, 1, 8'hA0, 8'hB0, 1); push(3, 0, 0, 0, 0);
      push(4, 0, 0, 0, 0); push(3, 0, 0, 0, 0);
      run_txn(0, 0, 0, 0);
      chk("ovf.set", {7'd0, status[6]}, 8'd1);
      clr_txn();
      push(1, 0, 0, 0, 0); push(3, 0, 0, 0, 0); push(4, 0, 0, 0, 0);
      push(3, 0, 0, 0, 0); push(5, 0, 0, 0, 0); push(3, 0, 0, 0, 0);
      run_txn(0, 0, 0, 0);
      chk("ovf.clr", {7'd0, status[6]}, 8'd0);

      // stuck transmit state -> timeout release and holdoff
      i2c_state = 3;
      tick();
      n = frozen ? 1 : 0;
      for (int k = 0; k < 40; k++) begin
         upd_valid = (k == 4);
         upd_x = 8'h77; upd_y = 8'h88; upd_err = 1'b1;
         tick();
         upd_valid = 1'b0;
         if (frozen) n++;
         else break;
      end
      chk("to.len", 8'(n), 8'(TO));
      chk("to.frozen", {7'd0, frozen}, 8'd0);
      tick();
      m_to = 1;
      m_apply(8'h77, 8'h88, 1'b1);
      chk_all("to.commit", 1'b0);
      chk("to.bit", {7'd0, status[5]}, 8'd1);
      live_upd(8'h3C, 8'h4D, 1'b0, 3'd3);
      live_upd(8'h5E, 8'h6F, 1'b1, 3'd2);
      i2c_state = 0;
      tick();
      chk_all("hold.exit", 1'b0);
      clr_txn();
      push(1, 0, 0, 0, 0); push(3, 0, 0, 0, 0); push(4, 0, 0, 0, 0);
      push(3, 0, 0, 0, 0); push(4, 0, 0, 0, 0); push(3, 0, 0, 0, 0);
      run_txn(0, 0, 0, 0);
      chk("to.clr", {7'd0, status[5]}, 8'd0);

      // update in the commit cycle replaces pending and flags overflow
      clr_txn();
      push(1, 1, 8'hC1, 8'hC2, 0); push(3, 0, 0, 0, 0);
      push(4, 0, 0, 0, 0);
      run_txn(1, 8'hD1, 8'hD2, 1);
      chk("cu.x", x_pos, 8'hD1);

      // sequence wrap, then a partial read keeps new_data
      do_reset();
      for (int k = 0; k < 16; k++)
         live_upd(8'($urandom), 8'($urandom), 1'b0, 3'd0);
      chk("wrap.status", status, 8'h80);
      clr_txn();
      push(1, 0, 0, 0, 0); push(3, 0, 0, 0, 0); push(4, 0, 0, 0, 0);
      run_txn(0, 0, 0, 0);
      chk("partial.nd", {7'd0, status[7]}, 8'd1);

      // randomized mix
      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(0, 2) == 0) begin
            for (int k = 0; k < int'($urandom_range(1, 3)); k++)
               live_upd(8'($urandom), 8'($urandom), 1'($urandom), 3'd0);
         end else begin
            gen_txn();
            run_txn($urandom_range(0, 3) == 0, 8'($urandom),
                    8'($urandom), 1'($urandom));
         end
      end

      // reset while frozen with pending
      i2c_state = 1;
      tick();
      i2c_state = 2; upd_valid = 1; upd_x = 8'hEE; upd_y = 8'hDD;
      tick();
      upd_valid = 0;
      #2 rst_n = 1'b0;
      #1;
      m_zero();
      chk_all("async_rst", 1'b0);
      i2c_state = 0;
      #3 rst_n = 1'b1;
      tick();
      chk_all("rst_done", 1'b0);
      live_upd(8'h21, 8'h43, 1'b0, 3'd0);
      chk("rst.first", status, 8'h81);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
